// File: rtl/ones_comp_csum.sv
// ones_comp_csum: streaming ones'-complement checksum engine.
//
// Accepts a packet as LANES x WIDTH-bit beats over a valid/ready handshake and
// accumulates every kept word with end-around carry. On the last beat, the
// final sum, its complement and the kept-word count are loaded into output
// registers and held on a valid/ready handshake until consumed.
//
// Optional feature (compile-time macro):
//   CSUM_ZERO_FIX_EN - when defined, a complement of zero is sent as all-ones
//                      (UDP "no checksum" convention).
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   in_valid    - input beat present
//   in_ready    - engine can take a beat (!csum_valid || csum_ready)
//   in_data     - LANES packed words, lane 0 in the low bits
//   in_keep     - per-lane enable; dropped lanes add 0 and are not counted
//   in_last     - final beat of packet
//   csum_valid  - result held
//   csum_ready  - downstream takes the result
//   sum         - ones'-complement sum of the packet
//   csum        - complement of sum
//   word_cnt    - kept words in packet, saturating at 16'hFFFF

module ones_comp_csum #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_keep,
  input  logic                   in_last,
  output logic                   csum_valid,
  input  logic                   csum_ready,
  output logic [WIDTH-1:0]       sum,
  output logic [WIDTH-1:0]       csum,
  output logic [15:0]            word_cnt
);

  // Carry headroom: acc plus LANES words never exceeds (LANES+1)*(2^WIDTH-1).
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned RW = WIDTH + CW;

  typedef enum logic [0:0] {StEmpty, StHeld} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] csum_q, csum_d;
  logic [15:0]      wcnt_q, wcnt_d;

  logic [RW-1:0]    raw;
  logic [WIDTH:0]   fold1;
  logic [WIDTH-1:0] folded;
  logic [WIDTH-1:0] inv;
  logic [3:0]       pop;
  logic [16:0]      cnt_sum;
  logic [15:0]      cnt_upd;
  logic             accept;

  // Wide sum of accumulator and kept lanes.
  always_comb begin
    raw = RW'(acc_q);
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_keep[i]) begin
        raw = raw + RW'(in_data[i*WIDTH +: WIDTH]);
        pop = pop + 4'd1;
      end
    end
  end

  // Two folds: the first leaves at most a single carry bit, the second absorbs
  // it without producing another. All-ones stays all-ones, and a nonzero set
  // of inputs can never reach zero.
  always_comb begin
    fold1  = (WIDTH+1)'(raw[WIDTH-1:0]) + (WIDTH+1)'(raw[RW-1:WIDTH]);
    folded = fold1[WIDTH-1:0] + WIDTH'(fold1[WIDTH]);
  end

  always_comb begin
    inv = ~folded;
`ifdef CSUM_ZERO_FIX_EN
    if (inv == '0) begin
      inv = '1;
    end
`endif
  end

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 17'(pop);
    cnt_upd = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign in_ready = (state_q == StEmpty) || csum_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    csum_d  = csum_q;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      StEmpty: ;
      StHeld:  if (csum_ready) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      if (in_last) begin
        // A last beat overrides the consume transition: the result is reloaded
        // and the accumulator restarts clean for the next packet.
        sum_d   = folded;
        csum_d  = inv;
        wcnt_d  = cnt_upd;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StHeld;
      end else begin
        acc_d = folded;
        cnt_d = cnt_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      csum_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      csum_q  <= csum_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign csum_valid = (state_q == StHeld);
  assign sum        = sum_q;
  assign csum       = csum_q;
  assign word_cnt   = wcnt_q;

endmodule

// File: tb/tb_ones_comp_csum.sv
// Testbench for ones_comp_csum: an 8-bit single-lane instance and a 16-bit
// two-lane instance, driven with directed vectors. Expected results are queued
// when a packet is issued and checked by per-instance monitors on handshake.

module tb_ones_comp_csum;

  typedef struct packed {
    logic [15:0] s;
    logic [15:0] c;
    logic [15:0] w;
  } exp_t;

`ifdef CSUM_ZERO_FIX_EN
  localparam logic [15:0] FF8_CSUM  = 16'h00FF;
  localparam logic [15:0] FF16_CSUM = 16'hFFFF;
`else
  localparam logic [15:0] FF8_CSUM  = 16'h0000;
  localparam logic [15:0] FF16_CSUM = 16'h0000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, 1-lane instance
  logic        rst8_n, v8, r8, l8, cv8, cr8;
  logic [7:0]  d8, s8, c8;
  logic [0:0]  k8;
  logic [15:0] w8;

  // 16-bit, 2-lane instance
  logic        rst16_n, v16, r16, l16, cv16, cr16;
  logic [31:0] d16;
  logic [1:0]  k16;
  logic [15:0] s16, c16, w16;

  ones_comp_csum #(.WIDTH(8), .LANES(1)) u8 (
    .clk       (clk),
    .rst_n     (rst8_n),
    .in_valid  (v8),
    .in_ready  (r8),
    .in_data   (d8),
    .in_keep   (k8),
    .in_last   (l8),
    .csum_valid(cv8),
    .csum_ready(cr8),
    .sum       (s8),
    .csum      (c8),
    .word_cnt  (w8)
  );

  ones_comp_csum #(.WIDTH(16), .LANES(2)) u16 (
    .clk       (clk),
    .rst_n     (rst16_n),
    .in_valid  (v16),
    .in_ready  (r16),
    .in_data   (d16),
    .in_keep   (k16),
    .in_last   (l16),
    .csum_valid(cv16),
    .csum_ready(cr16),
    .sum       (s16),
    .csum      (c16),
    .word_cnt  (w16)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q16[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic [15:0] c, input logic [15:0] w);
    exp_t e;
    e.s = s;
    e.c = c;
    e.w = w;
    return e;
  endfunction

  // Monitors: pop and compare whenever a result is handed over.
  always @(negedge clk) begin
    if (rst8_n && cv8 && cr8) begin
      if (q8.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL u8_unexpected: got result %h, expected none", s8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("u8_sum", 16'(s8), e.s);
        check("u8_csum", 16'(c8), e.c);
        check("u8_cnt", w8, e.w);
      end
    end
  end

  always @(negedge clk) begin
    if (rst16_n && cv16 && cr16) begin
      if (q16.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL u16_unexpected: got result %h, expected none", s16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("u16_sum", s16, e.s);
        check("u16_csum", c16, e.c);
        check("u16_cnt", w16, e.w);
      end
    end
  end

  // Present one beat; returns #1 after the edge that accepted it.
  task automatic beat8(input logic [7:0] d, input logic last);
    int n;
    n  = 0;
    v8 = 1'b1;
    d8 = d;
    k8 = 1'b1;
    l8 = last;
    @(negedge clk);
    while (!r8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!r8) begin
      n_vec++;
      n_err++;
      $display("FAIL u8_ready_timeout: got in_ready 0, expected 1");
    end
    @(posedge clk);
    #1;
    v8 = 1'b0;
    l8 = 1'b0;
  endtask

  task automatic beat16(input logic [31:0] d, input logic [1:0] k, input logic last);
    int n;
    n   = 0;
    v16 = 1'b1;
    d16 = d;
    k16 = k;
    l16 = last;
    @(negedge clk);
    while (!r16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!r16) begin
      n_vec++;
      n_err++;
      $display("FAIL u16_ready_timeout: got in_ready 0, expected 1");
    end
    @(posedge clk);
    #1;
    v16 = 1'b0;
    l16 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst8_n = 1'b0; rst16_n = 1'b0;
    v8 = 1'b0; d8 = '0; k8 = '0; l8 = 1'b0; cr8 = 1'b1;
    v16 = 1'b0; d16 = '0; k16 = '0; l16 = 1'b0; cr16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst8_n = 1'b1; rst16_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_u8_ready", 16'(r8), 16'h1);
    check("rst_u8_valid", 16'(cv8), 16'h0);
    check("rst_u8_sum", 16'(s8), 16'h0);
    check("rst_u8_csum", 16'(c8), 16'h0);
    check("rst_u8_cnt", w8, 16'h0);
    check("rst_u16_ready", 16'(r16), 16'h1);
    check("rst_u16_valid", 16'(cv16), 16'h0);
    check("rst_u16_sum", s16, 16'h0);
    check("rst_u16_csum", c16, 16'h0);
    check("rst_u16_cnt", w16, 16'h0);
    @(posedge clk);
    #1;

    // AB + CD = 0x178 -> 0x79; valid one cycle after the last beat
    q8.push_back(mk(16'h79, 16'h86, 16'd2));
    beat8(8'hAB, 1'b0);
    beat8(8'hCD, 1'b1);
    check("u8_latency_valid", 16'(cv8), 16'h1);

    // Negative zero preserved: FF + FF = FF
    q8.push_back(mk(16'hFF, FF8_CSUM, 16'd2));
    beat8(8'hFF, 1'b0);
    beat8(8'hFF, 1'b1);

    // 1F + F0 = 0x10F -> 0x10
    q8.push_back(mk(16'h10, 16'hEF, 16'd2));
    beat8(8'h1F, 1'b0);
    beat8(8'hF0, 1'b1);

    // Reset mid-packet discards the partial sum
    beat8(8'h01, 1'b0);
    beat8(8'h02, 1'b0);
    beat8(8'h03, 1'b0);
    rst8_n = 1'b0;
    @(posedge clk);
    #1;
    rst8_n = 1'b1;
    check("u8_reset_valid", 16'(cv8), 16'h0);
    q8.push_back(mk(16'h79, 16'h86, 16'd2));
    beat8(8'hAB, 1'b0);
    beat8(8'hCD, 1'b1);
    @(posedge clk);
    #1;

    // Backpressure: result held stable, in_ready low
    cr8 = 1'b0;
    q8.push_back(mk(16'h12, 16'hED, 16'd1));
    beat8(8'h12, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("u8_bp_valid", 16'(cv8), 16'h1);
      check("u8_bp_ready", 16'(r8), 16'h0);
      check("u8_bp_sum", 16'(s8), 16'h12);
      check("u8_bp_csum", 16'(c8), 16'hED);
      check("u8_bp_cnt", w8, 16'd1);
    end
    @(posedge clk);
    #1;
    // Consume and reload in the same cycle
    q8.push_back(mk(16'h34, 16'hCB, 16'd1));
    cr8 = 1'b1;
    beat8(8'h34, 1'b1);
    check("u8_reload_valid", 16'(cv8), 16'h1);

    // IPv4 header, two words per beat, lane 0 first
    q16.push_back(mk(16'h479E, 16'hB861, 16'd10));
    beat16(32'h0073_4500, 2'b11, 1'b0);
    beat16(32'h4000_0000, 2'b11, 1'b0);
    beat16(32'h0000_4011, 2'b11, 1'b0);
    beat16(32'h0001_C0A8, 2'b11, 1'b0);
    beat16(32'h00C7_C0A8, 2'b11, 1'b1);

    // Keep mask: FFFF + 0002 wraps to 0002
    q16.push_back(mk(16'h0002, 16'hFFFD, 16'd2));
    beat16(32'h0001_FFFF, 2'b01, 1'b0);
    beat16(32'h0002_0000, 2'b10, 1'b1);

    // Empty packet: all lanes dropped
    q16.push_back(mk(16'h0000, 16'hFFFF, 16'd0));
    beat16(32'h1234_5678, 2'b00, 1'b1);

    // Both lanes all-ones in one beat: FFFF + FFFF = FFFF
    q16.push_back(mk(16'hFFFF, FF16_CSUM, 16'd2));
    beat16(32'hFFFF_FFFF, 2'b11, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("u8_queue_drained", 16'(q8.size()), 16'd0);
    check("u16_queue_drained", 16'(q16.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
